// File: rtl/dds_poly_engine.sv
// Multi-voice wavetable DDS: time-shared phase accumulators, one registered sine ROM,
// per-voice envelope scaling and a summing mixer, programmed by a byte-command parser.
module dds_poly_engine #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int FREQ_W     = 16,
    parameter int ADDR_W     = 12,
    parameter int SAMPLE_W   = 16,
    parameter int ENV_W      = 8,
    parameter int OUT_W      = 8,
    parameter int TICK_DIV   = 500
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_data,
    input  logic                cmd_abort,
    output logic                cmd_error,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_q,
    output logic [OUT_W-1:0]    sample_out,
    output logic                sample_valid,
    output logic                dbg_parse_state,
    output logic [1:0]          dbg_scan_state
);
    localparam int LOG_N  = $clog2(NUM_VOICES);
    localparam int VW     = (LOG_N > 0) ? LOG_N : 1;
    localparam int ACC_W  = SAMPLE_W + LOG_N;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SHIFT  = LOG_N + SAMPLE_W - OUT_W;

    localparam logic [3:0] OP_FREQ = 4'd1;
    localparam logic [3:0] OP_ENV  = 4'd2;
    localparam logic [3:0] OP_PRST = 4'd3;

    typedef enum logic {P_IDLE, P_PAYLOAD} parse_t;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_OUT} scan_t;

    parse_t p_state, p_next;
    scan_t  s_state, s_next;

    logic [PHASE_W-1:0] phase [NUM_VOICES];
    logic [FREQ_W-1:0]  freq  [NUM_VOICES];
    logic [ENV_W-1:0]   env   [NUM_VOICES];

    // Parser context for the frame in flight.
    logic [3:0]    p_op;
    logic [VW-1:0] p_voice;
    logic          p_bad;
    logic          p_left;
    logic [7:0]    p_stage;
    logic          prst_pend;
    logic [VW-1:0] prst_v;

    logic [3:0] op;
    logic       op_known;
    logic       v_ok;
    logic       ld_hdr, ld_stage, freq_we, env_we, prst_req;

    assign op       = cmd_data[7:4];
    assign op_known = (op == OP_FREQ) || (op == OP_ENV) || (op == OP_PRST);
    assign v_ok     = ({1'b0, cmd_data[3:0]} < 5'(NUM_VOICES));

    // cmd_valid is a one-cycle byte strobe with no backpressure: every strobed byte is
    // consumed in its own cycle; cmd_abort in the same cycle discards the byte.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) p_state <= P_IDLE;
        else         p_state <= p_next;
    end

    always_comb begin
        p_next    = p_state;
        cmd_error = 1'b0;
        ld_hdr    = 1'b0;
        ld_stage  = 1'b0;
        freq_we   = 1'b0;
        env_we    = 1'b0;
        prst_req  = 1'b0;
        if (cmd_abort) begin
            p_next = P_IDLE;
        end else if (cmd_valid) begin
            case (p_state)
                P_IDLE: begin
                    if (!op_known) begin
                        cmd_error = 1'b1;
                    end else begin
                        cmd_error = !v_ok;
                        if (op == OP_PRST) begin
                            prst_req = v_ok;
                        end else begin
                            p_next = P_PAYLOAD;
                            ld_hdr = 1'b1;
                        end
                    end
                end
                P_PAYLOAD: begin
                    if (p_left) begin
                        ld_stage = 1'b1;
                    end else begin
                        p_next  = P_IDLE;
                        freq_we = !p_bad && (p_op == OP_FREQ);
                        env_we  = !p_bad && (p_op == OP_ENV);
                    end
                end
                default: p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            p_op      <= '0;
            p_voice   <= '0;
            p_bad     <= 1'b0;
            p_left    <= 1'b0;
            p_stage   <= '0;
            prst_pend <= 1'b0;
            prst_v    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq[i] <= '0;
                env[i]  <= '0;
            end
        end else begin
            prst_pend <= prst_req;
            if (prst_req) prst_v <= cmd_data[VW-1:0];
            if (ld_hdr) begin
                p_op    <= op;
                p_voice <= cmd_data[VW-1:0];
                p_bad   <= !v_ok;
                p_left  <= (op == OP_FREQ);
            end
            if (ld_stage) begin
                p_stage <= cmd_data;
                p_left  <= 1'b0;
            end
            if (freq_we) freq[p_voice] <= FREQ_W'({p_stage, cmd_data});
            if (env_we)  env[p_voice]  <= ENV_W'(cmd_data);
        end
    end

    logic [TICK_W-1:0] tick_cnt;
    logic              wrap;
    logic [VW-1:0]     slot;
    logic              last_slot;
    logic              acc_en;
    logic [VW-1:0]     acc_v;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [SAMPLE_W+ENV_W-1:0] prod;
    logic              addr_ld;
    logic [VW-1:0]     addr_v;

    assign wrap      = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign last_slot = (slot == VW'(NUM_VOICES - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) s_state <= S_IDLE;
        else         s_state <= s_next;
    end

    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:  if (wrap) s_next = S_ADDR;
            S_ADDR:  if (last_slot) s_next = S_DRAIN;
            S_DRAIN: s_next = S_OUT;
            S_OUT:   s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // rom_addr is registered one cycle ahead so slot v shows on the bus in S_ADDR slot v.
    assign addr_ld = ((s_state == S_IDLE) && wrap) || ((s_state == S_ADDR) && !last_slot);
    assign addr_v  = (s_state == S_IDLE) ? '0 : slot + 1'b1;
    assign prod    = rom_q * env[acc_v];
    assign acc_sum = acc + ACC_W'(prod >> ENV_W);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tick_cnt   <= '0;
            slot       <= '0;
            acc_en     <= 1'b0;
            acc_v      <= '0;
            acc        <= '0;
            rom_addr   <= '0;
            sample_out <= '0;
            for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
        end else begin
            tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
            if ((s_state == S_IDLE) && wrap) slot <= '0;
            else if (s_state == S_ADDR)      slot <= slot + 1'b1;
            if (addr_ld) rom_addr <= phase[addr_v][PHASE_W-1 -: ADDR_W];
            acc_en <= (s_state == S_ADDR);
            acc_v  <= slot;
            if (s_state == S_DRAIN) begin
                sample_out <= acc_sum[ACC_W-1:SHIFT];
                acc        <= '0;
            end else if (acc_en) begin
                acc <= acc_sum;
            end
            // A pending phase reset overrides the scan increment for that voice.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (prst_pend && (prst_v == VW'(i)))
                    phase[i] <= '0;
                else if (acc_en && (acc_v == VW'(i)))
                    phase[i] <= phase[i] + PHASE_W'(freq[i]);
            end
        end
    end

    assign sample_valid    = (s_state == S_OUT);
    assign dbg_parse_state = p_state;
    assign dbg_scan_state  = s_state;

endmodule

// File: tb/tb_dds_poly_engine.sv
// Directed bench for dds_poly_engine: constant-0xFFFF registered ROM model, command
// frames driven byte by byte, outputs sampled at the falling clock edge.
module tb_dds_poly_engine;
    localparam int NV = 4;
    localparam int TD = 100;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_abort;
    logic        cmd_error;
    logic [11:0] rom_addr;
    logic [15:0] rom_q;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        dbg_parse_state;
    logic [1:0]  dbg_scan_state;

    int vectors     = 0;
    int miscompares = 0;
    int err_cnt     = 0;
    int err0;
    int cyc         = 0;
    int last_sv_cyc = 0;
    int prev_sv;
    int rel_cyc;
    int target;
    logic [11:0] cap [NV];

    dds_poly_engine #(
        .NUM_VOICES(NV), .PHASE_W(24), .FREQ_W(16), .ADDR_W(12),
        .SAMPLE_W(16), .ENV_W(8), .OUT_W(8), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .nreset(nreset),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_abort(cmd_abort),
        .cmd_error(cmd_error), .rom_addr(rom_addr), .rom_q(rom_q),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .dbg_parse_state(dbg_parse_state), .dbg_scan_state(dbg_scan_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_q <= 16'hFFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        #1;
        if (cmd_error === 1'b1) err_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic abort_pulse();
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_sv();
        bit got = 0;
        for (int i = 0; i < 2 * TD && !got; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) got = 1;
        end
        if (!got) check("sample_valid_timeout", 32'd0, 32'd1);
        last_sv_cyc = cyc;
    endtask

    // Capture rom_addr for every slot of the scan following the last sample_valid.
    task automatic capture();
        target = last_sv_cyc + TD - NV - 1;
        if (cyc > target) check("capture_late", cyc, target);
        while (cyc < target) @(negedge clk);
        for (int s = 0; s < NV; s++) begin
            cap[s] = rom_addr;
            @(negedge clk);
        end
    endtask

    initial begin
        nreset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_abort = 1'b0;
        cmd_data  = 8'h00;
        repeat (3) @(negedge clk);

        // T1: reset values, first sample timing, sample period
        check("rst_sample_out", sample_out, 8'h00);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_rom_addr", rom_addr, 12'h000);
        check("rst_cmd_error", cmd_error, 1'b0);
        nreset  = 1'b1;
        rel_cyc = cyc;
        wait_sv();
        check("t1_first_sv_delay", last_sv_cyc - rel_cyc, TD - 1 + NV + 2);
        check("t1_sample_zero", sample_out, 8'h00);
        check("t1_rom_addr_zero", rom_addr, 12'h000);
        prev_sv = last_sv_cyc;
        wait_sv();
        check("t1_sv_period", last_sv_cyc - prev_sv, TD);
        check("t1_sample_zero2", sample_out, 8'h00);

        // T2: full-scale ROM, all voices at max envelope, then only voice 0
        send(8'h20); send(8'hFF);
        send(8'h21); send(8'hFF);
        send(8'h22); send(8'hFF);
        send(8'h23); send(8'hFF);
        wait_sv();
        check("t2_all_voices", sample_out, 8'hFE);
        send(8'h21); send(8'h00);
        send(8'h22); send(8'h00);
        send(8'h23); send(8'h00);
        wait_sv();
        check("t2_voice0_only", sample_out, 8'h3F);

        // T3: phase wrap after 257 scans, then phase reset
        send(8'h10); send(8'hFF); send(8'hFF);
        repeat (257) wait_sv();
        capture();
        check("t3_slot0_after_257", cap[0], 12'h00F);
        check("t3_slot1_idle", cap[1], 12'h000);
        wait_sv();
        send(8'h30);
        capture();
        check("t3_slot0_after_prst", cap[0], 12'h000);
        check("t3_slot3_idle", cap[3], 12'h000);

        // T4: out-of-range voice frame consumed, then env0 write
        wait_sv();
        err0 = err_cnt;
        send(8'h17); send(8'hAA); send(8'hBB);
        send(8'h20); send(8'h80);
        check("t4_error_pulses", err_cnt - err0, 1);
        wait_sv();
        check("t4_env0_half", sample_out, 8'h1F);
        wait_sv();
        capture();
        check("t4_slot3_unchanged", cap[3], 12'h000);
        check("t4_slot2_unchanged", cap[2], 12'h000);

        // T5: aborted freq frame is dropped, next frame parses cleanly
        wait_sv();
        err0 = err_cnt;
        send(8'h11); send(8'h12);
        abort_pulse();
        send(8'h21); send(8'h40);
        check("t5_no_error", err_cnt - err0, 0);
        wait_sv();
        check("t5_env1_quarter", sample_out, 8'h2F);
        wait_sv();
        capture();
        check("t5_freq1_zero", cap[1], 12'h000);

        // T6: asynchronous reset in the middle of a scan
        wait_sv();
        target = last_sv_cyc + TD - NV + 1;
        while (cyc < target) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("t6_sample_out_rst", sample_out, 8'h00);
        check("t6_sample_valid_rst", sample_valid, 1'b0);
        check("t6_rom_addr_rst", rom_addr, 12'h000);
        check("t6_cmd_error_rst", cmd_error, 1'b0);
        repeat (2) @(negedge clk);
        nreset  = 1'b1;
        rel_cyc = cyc;
        wait_sv();
        check("t6_first_sv_delay", last_sv_cyc - rel_cyc, TD - 1 + NV + 2);
        check("t6_env_cleared", sample_out, 8'h00);
        capture();
        check("t6_phase0_cleared", cap[0], 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
